// File: rtl/busresponder_ram_if.sv
// CPU-bus request/response bundle between one requester and its memory responders.
// The requester holds its request until it sees ready; the responder pulses ready for one cycle.
interface busresponder_ram_if;
  logic [29:0] address;
  logic [31:0] data_in;
  logic [3:0]  data_strobes;
  logic        read;
  logic        write;
  logic [31:0] data_out;
  logic        ready;
  logic        bus_error;

  modport master (
    output address, data_in, data_strobes, read, write,
    input  data_out, ready, bus_error
  );

  modport slave (
    input  address, data_in, data_strobes, read, write,
    output data_out, ready, bus_error
  );
endinterface

// File: rtl/busresponder_ram.sv
// Byte-lane RAM responder with address-window decode; ready/bus_error pulse 1+WAIT_STATES cycles after request.
// Requester holds the request until ready, then must drop it; BUSRESPONDER_WRITE_PROTECT_EN adds write_protect.
module busresponder_ram #(
  parameter logic [31:0] BASE_ADDR   = 32'h00000000,
  parameter int          ADDR_WIDTH  = 10,
  parameter int          WAIT_STATES = 0
) (
  input  logic clock,
  input  logic reset,
`ifdef BUSRESPONDER_WRITE_PROTECT_EN
  input  logic write_protect,
`endif
  busresponder_ram_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} state_t;

  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic take, go_ack;

  logic [ADDR_WIDTH-1:0] idx_q;
  logic [3:0]            strb_q;
  logic [31:0]           din_q;
  logic                  rd_q, wr_q;
  logic [31:0]           dout_q;
  logic [31:0]           mem [2**ADDR_WIDTH];

  logic                  sel, req;
  logic [ADDR_WIDTH-1:0] cur_idx;
  logic [3:0]            cur_strb;
  logic                  cur_rd, cur_wr, cur_read_ok;
  logic                  err_q, wp_hit, mem_we;

  assign sel = (bus.address[29:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH+2]);
  assign req = bus.read | bus.write;

  // With zero wait states the read data is fetched in the request cycle itself,
  // before anything is latched, so decode from the live bus while idle.
  assign cur_idx     = (state == IDLE) ? bus.address[ADDR_WIDTH-1:0] : idx_q;
  assign cur_strb    = (state == IDLE) ? bus.data_strobes : strb_q;
  assign cur_rd      = (state == IDLE) ? bus.read : rd_q;
  assign cur_wr      = (state == IDLE) ? bus.write : wr_q;
  assign cur_read_ok = cur_rd && !cur_wr && (cur_strb != 4'b0000);

  assign err_q = (rd_q && wr_q) || (strb_q == 4'b0000);
`ifdef BUSRESPONDER_WRITE_PROTECT_EN
  assign wp_hit = wr_q && write_protect;
`else
  assign wp_hit = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    take     = 1'b0;
    go_ack   = 1'b0;
    case (state)
      IDLE: begin
        if (sel && req) begin
          take   = 1'b1;
          cnt_nx = 4'(WAIT_STATES);
          if (WAIT_STATES > 0) begin
            state_nx = WAIT;
          end else begin
            state_nx = ACK;
            go_ack   = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - 4'd1;
          if (cnt == 4'd1) begin
            state_nx = ACK;
            go_ack   = 1'b1;
          end
        end
      end
      ACK:     state_nx = HOLD;
      HOLD:    if (!req) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.ready     = (state == ACK);
  assign bus.bus_error = (state == ACK) && (err_q || wp_hit);
  assign bus.data_out  = dout_q;
  assign mem_we        = (state == ACK) && !reset && wr_q && !err_q && !wp_hit;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      dout_q <= 32'hffffffff;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (go_ack && cur_read_ok) dout_q <= mem[cur_idx];
    end
  end

  always_ff @(posedge clock) begin
    if (take) begin
      idx_q  <= bus.address[ADDR_WIDTH-1:0];
      strb_q <= bus.data_strobes;
      din_q  <= bus.data_in;
      rd_q   <= bus.read;
      wr_q   <= bus.write;
    end
  end

  always_ff @(posedge clock) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we && strb_q[b]) mem[idx_q][8*b +: 8] <= din_q[8*b +: 8];
    end
  end
endmodule

// File: tb/tb_busresponder_ram.sv
// Two responders (0 and 3 wait states) on separate buses, checked against a word-array model.
module tb_busresponder_ram;
  localparam int WS0 = 0;
  localparam int WS1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst    [2];
  logic [29:0] addr_r [2];
  logic [31:0] din_r  [2];
  logic [3:0]  strb_r [2];
  logic        rd_r   [2];
  logic        wr_r   [2];
  logic [31:0] dout   [2];
  logic        rdy    [2];
  logic        err    [2];
  logic        wp;

  busresponder_ram_if b0 ();
  busresponder_ram_if b1 ();

  assign b0.address = addr_r[0]; assign b0.data_in = din_r[0]; assign b0.data_strobes = strb_r[0];
  assign b0.read = rd_r[0]; assign b0.write = wr_r[0];
  assign b1.address = addr_r[1]; assign b1.data_in = din_r[1]; assign b1.data_strobes = strb_r[1];
  assign b1.read = rd_r[1]; assign b1.write = wr_r[1];
  assign dout[0] = b0.data_out; assign rdy[0] = b0.ready; assign err[0] = b0.bus_error;
  assign dout[1] = b1.data_out; assign rdy[1] = b1.ready; assign err[1] = b1.bus_error;

  busresponder_ram #(.BASE_ADDR(32'h00000000), .ADDR_WIDTH(10), .WAIT_STATES(WS0)) u0 (
    .clock(clk), .reset(rst[0]),
`ifdef BUSRESPONDER_WRITE_PROTECT_EN
    .write_protect(wp),
`endif
    .bus(b0.slave)
  );
  busresponder_ram #(.BASE_ADDR(32'h00010000), .ADDR_WIDTH(10), .WAIT_STATES(WS1)) u1 (
    .clock(clk), .reset(rst[1]),
`ifdef BUSRESPONDER_WRITE_PROTECT_EN
    .write_protect(wp),
`endif
    .bus(b1.slave)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mm [2][1024];
  logic [31:0] exp_dout [2];
  bit          allow [2];
  bit          mon_en = 1'b0;

  function automatic logic [29:0] base_of(input int d);
    return (d == 0) ? 30'h0 : 30'h4000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One complete bus transaction with expectations taken from the word-array model.
  task automatic access(input int d, input bit r, input bit w, input int idx,
                        input logic [31:0] data, input logic [3:0] s, input int hold,
                        output logic [31:0] rdata, output int lat);
    bit sel;
    bit e_err;
    sel   = (idx < 1024);
    e_err = (r && w) || (s == 4'b0000) || (w && wp);
    @(posedge clk); #1;
    addr_r[d] = base_of(d) + 30'(idx);
    din_r[d]  = data;
    strb_r[d] = s;
    rd_r[d]   = r;
    wr_r[d]   = w;
    allow[d]  = sel;
    lat   = -1;
    rdata = 32'h0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (rdy[d]) begin
        lat   = n;
        rdata = dout[d];
        break;
      end
    end
    if (!sel) begin
      check("unselected_no_ready", 32'(lat), 32'hffffffff);
    end else begin
      check("latency", 32'(lat), 32'(1 + ((d == 0) ? WS0 : WS1)));
      if (lat >= 0) begin
        check("bus_error", {31'b0, err[d]}, {31'b0, e_err});
        if (!e_err && r) begin
          check("read_data", rdata, mm[d][idx]);
          exp_dout[d] = mm[d][idx];
        end else begin
          check("data_out_unchanged", rdata, exp_dout[d]);
        end
        if (!e_err && w) begin
          for (int b = 0; b < 4; b++)
            if (s[b]) mm[d][idx][8*b +: 8] = data[8*b +: 8];
        end
      end
      @(posedge clk);
      allow[d] = 1'b0;
      repeat (hold) @(posedge clk);
    end
    #1;
    rd_r[d] = 1'b0; wr_r[d] = 1'b0; strb_r[d] = 4'b0; din_r[d] = 32'h0;
    @(posedge clk);
  endtask

  // Write to word 5 that is cut short in wait cycle 2, by dropping the request or by reset.
  task automatic abort_write(input int d, input bit use_reset);
    @(posedge clk); #1;
    addr_r[d] = base_of(d) + 30'd5; din_r[d] = 32'h0; strb_r[d] = 4'hf;
    wr_r[d] = 1'b1; rd_r[d] = 1'b0; allow[d] = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    if (use_reset) rst[d] = 1'b1;
    else wr_r[d] = 1'b0;
    @(posedge clk); #1;
    if (use_reset) begin
      rst[d] = 1'b0;
      wr_r[d] = 1'b0;
      exp_dout[d] = 32'hffffffff;
    end
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      check(use_reset ? "reset_no_ready" : "abort_no_ready", {31'b0, rdy[d]}, 32'h0);
    end
  endtask

  // Every cycle: no stray ready, no error without ready, data_out holds between reads.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int d = 0; d < 2; d++) begin
          if (!allow[d]) check("stray_ready", {31'b0, rdy[d]}, 32'h0);
          if (!rdy[d])   check("error_without_ready", {31'b0, err[d]}, 32'h0);
          if (!rdy[d] && !rst[d]) check("data_out_hold", dout[d], exp_dout[d]);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required end before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          lat;
    int          kind;
    int          idx;
    logic [3:0]  s;
    wp = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; addr_r[d] = 30'h0; din_r[d] = 32'h0; strb_r[d] = 4'h0;
      rd_r[d] = 1'b0; wr_r[d] = 1'b0; allow[d] = 1'b0; exp_dout[d] = 32'hffffffff;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("reset_data_out", dout[d], 32'hffffffff);
      check("reset_ready", {31'b0, rdy[d]}, 32'h0);
      check("reset_bus_error", {31'b0, err[d]}, 32'h0);
      rst[d] = 1'b0;
    end
    mon_en = 1'b1;

    // Full-word write/read, then a single-lane write.
    access(0, 1'b0, 1'b1, 5, 32'hdeadbeef, 4'b1111, 0, rd, lat);
    check("ws0_write_latency", 32'(lat), 32'd1);
    access(0, 1'b1, 1'b0, 5, 32'h0, 4'b1111, 0, rd, lat);
    check("ws0_read_latency", 32'(lat), 32'd1);
    check("read_deadbeef", rd, 32'hdeadbeef);
    access(0, 1'b0, 1'b1, 5, 32'hffff12ff, 4'b0010, 0, rd, lat);
    access(0, 1'b1, 1'b0, 5, 32'h0, 4'b1111, 0, rd, lat);
    check("read_lane1_merge", rd, 32'hdead12ef);

    // Error requests leave memory and data_out alone.
    access(0, 1'b1, 1'b1, 5, 32'h11111111, 4'b1111, 0, rd, lat);
    check("both_high_error", {31'b0, err[0]}, 32'h0);
    access(0, 1'b0, 1'b1, 5, 32'h22222222, 4'b0000, 0, rd, lat);
    access(0, 1'b1, 1'b0, 5, 32'h0, 4'b1111, 0, rd, lat);
    check("after_errors", rd, 32'hdead12ef);

    // Wait states, held request, abort and reset.
    access(1, 1'b0, 1'b1, 5, 32'h12345678, 4'b1111, 0, rd, lat);
    access(1, 1'b1, 1'b0, 5, 32'h0, 4'b1111, 5, rd, lat);
    check("ws3_read_latency", 32'(lat), 32'd4);
    check("ws3_read_data", rd, 32'h12345678);
    abort_write(1, 1'b0);
    access(1, 1'b1, 1'b0, 5, 32'h0, 4'b1111, 0, rd, lat);
    check("after_abort", rd, 32'h12345678);
    abort_write(1, 1'b1);
    access(1, 1'b1, 1'b0, 5, 32'h0, 4'b1111, 0, rd, lat);
    check("after_reset", rd, 32'h12345678);

    // Outside the window: no response for well over 20 cycles.
    access(0, 1'b0, 1'b1, 1029, 32'h55555555, 4'b1111, 0, rd, lat);
    access(0, 1'b1, 1'b0, 1029, 32'h0, 4'b1111, 0, rd, lat);

`ifdef BUSRESPONDER_WRITE_PROTECT_EN
    wp = 1'b1;
    access(0, 1'b0, 1'b1, 5, 32'h0badf00d, 4'b1111, 0, rd, lat);
    access(0, 1'b1, 1'b0, 5, 32'h0, 4'b1111, 0, rd, lat);
    check("wp_read_allowed", rd, 32'hdead12ef);
    wp = 1'b0;
    access(0, 1'b1, 1'b0, 5, 32'h0, 4'b1111, 0, rd, lat);
    check("wp_memory_unchanged", rd, 32'hdead12ef);
`endif

    // Randomised traffic over words 0..7 of each responder.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) access(d, 1'b0, 1'b1, i, $urandom, 4'b1111, 0, rd, lat);
      for (int i = 0; i < 120; i++) begin
        kind = $urandom_range(0, 9);
        idx  = $urandom_range(0, 7);
        s    = 4'($urandom_range(1, 15));
        case (kind)
          0, 1, 2, 3: access(d, 1'b1, 1'b0, idx, $urandom, s, $urandom_range(0, 3), rd, lat);
          4, 5, 6, 7: access(d, 1'b0, 1'b1, idx, $urandom, s, $urandom_range(0, 3), rd, lat);
          8:          access(d, 1'b1, 1'b1, idx, $urandom, s, $urandom_range(0, 3), rd, lat);
          default:    access(d, 1'b0, 1'b1, idx, $urandom, 4'b0000, $urandom_range(0, 3), rd, lat);
        endcase
      end
    end

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/busresponder_ram.md
Name: busresponder_ram

Overview:
- Bus-side responder (slave) for the CPU bus interface: accepts word address, byte strobes, write data and read/write requests; returns the full 32-bit word plus a completion handshake.
- Byte-lane-writable synchronous RAM with a programmable wait-state counter and address-window decode.
- Sits between the bus interface and memory; several instances, each with its own BASE_ADDR, share one bus.

Parameters:
- BASE_ADDR, 32'h00000000, window base; must be aligned to the window size.
- ADDR_WIDTH, 10, word-address bits; window is 2^ADDR_WIDTH 32-bit words.
- WAIT_STATES, 0, extra cycles (0..15) inserted before completion.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- address  input  30  word address, bits [31:2].
- data_in  input  32  write data, byte lanes already positioned (lane 3 = bits 31:24).
- data_strobes  input  4  byte-lane enables; bit 3 = bits 31:24.
- read  input  1  read request.
- write  input  1  write request.
- data_out  output  32  read data, full word.
- ready  output  1  one-cycle completion pulse.
- bus_error  output  1  one-cycle error pulse, coincident with ready.

Behaviour:
- Reset: state IDLE; ready=0, bus_error=0, data_out=32'hffffffff, wait counter=0. Memory contents untouched and undefined after power-up.
- select = (address[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]); index = address[ADDR_WIDTH+1:2].
- Unselected: no response; ready and bus_error stay 0.
- FSM states: IDLE, WAIT, ACK, HOLD.
- IDLE:
  - If select and (read or write): latch index, strobes, data_in and direction; load counter with WAIT_STATES.
  - Go to WAIT if WAIT_STATES>0, else to ACK.
- WAIT:
  - Decrement counter; on reaching 0 go to ACK.
  - If read and write both low: abort to IDLE, no memory write, no pulse.
- ACK (one cycle, ready=1):
  - Error when read and write were both high, or strobes==4'b0000. In that case bus_error=1, no write, and data_out is unchanged.
  - Valid write: only the strobed lanes of mem[index] are updated.
  - Valid read: data_out = mem[index] (all four lanes). data_out holds this value until the next read completes.
  - Go to HOLD.
- HOLD: wait until read and write are both low, then IDLE. This prevents a repeated write while the requester holds its request.
- Latency: request sampled in cycle 0; ready asserted in cycle 1+WAIT_STATES.
- Request changes after the latch point (address, strobes, data) are ignored; the latched values are used.
- Reset in any state: to IDLE, pending write discarded, ready and bus_error cleared the same edge.
- Strobe patterns are not checked against alignment; any non-zero pattern is legal.

Optional Feature:
- BUSRESPONDER_WRITE_PROTECT_EN defined:
  - Adds input port write_protect (1 bit).
  - A write reaching ACK while write_protect=1 gives ready=1, bus_error=1, and memory is unchanged.
  - write_protect is sampled in ACK. Reads are unaffected.
- Not defined: port absent; all valid writes are performed.

Test Plan:
- WAIT_STATES=0. Write 32'hdeadbeef to word 5 with strobes 1111, then read word 5 -> ready in cycle 1 of each access; data_out=32'hdeadbeef; bus_error=0.
- Word 5 = 32'hdeadbeef. Write data_in 32'hffff12ff with strobes 0010, then read -> data_out=32'hdead12ef.
- WAIT_STATES=3. Read request -> ready high exactly in cycle 4. Request held for 5 more cycles -> no second ready; a new request is accepted only after read drops.
- read and write both high, and separately strobes 0000 -> ready=1 and bus_error=1 in the same cycle; memory unchanged.
- WAIT_STATES=3. Write aborted, or reset asserted, in WAIT cycle 2 -> no ready; subsequent read returns the old word.
- Address outside the window -> ready stays 0 for 20 cycles. With the macro defined and write_protect=1, a write -> bus_error=1 and memory unchanged.
